// File: rtl/id_scoreboard_if.sv
// Handshake bundle between the ID stage / WB stage and the register scoreboard.
//   master : pipeline side (drives the instruction in ID and the WB write port,
//            receives stall/issue/busy/idle/err)
//   slave  : scoreboard side
interface id_scoreboard_if;
    logic [31:0] instruccion;       // instruction in ID; rs=[25:21], rt=[20:16]
    logic        id_valid;          // ID holds a real instruction
    logic        id_uses_rt;        // rt is a source operand
    logic        id_writes;         // instruction writes a register
    logic [4:0]  id_dest;           // resolved destination register
    logic        wb_RegWrite;       // register bank write enable
    logic [4:0]  wb_WriteRegister;  // register bank write address
    logic        stall;             // hold PC and IF/ID, bubble into ID/EX
    logic        issue;             // instruction in ID advances this cycle
    logic        busy_rs;           // rs source blocked
    logic        busy_rt;           // rt source blocked
    logic        idle;              // no pending writes anywhere
    logic        err;               // sticky: release with nothing pending

    modport master (
        output instruccion, id_valid, id_uses_rt, id_writes, id_dest,
        output wb_RegWrite, wb_WriteRegister,
        input  stall, issue, busy_rs, busy_rt, idle, err
    );

    modport slave (
        input  instruccion, id_valid, id_uses_rt, id_writes, id_dest,
        input  wb_RegWrite, wb_WriteRegister,
        output stall, issue, busy_rs, busy_rt, idle, err
    );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard / issue controller for the MIPS32 ID stage.
// Keeps a pending-write counter per architectural register ($1..$31) and
// stalls the instruction in ID while a source register has an outstanding
// write or its destination counter is saturated.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   sb     : id_scoreboard_if.slave (ID request, WB release, stall/issue status)
// Parameter:
//   CNT_W  : counter width; up to 2^CNT_W-1 writes in flight per register
// Optional feature macro: WB_BYPASS_EN
//   defined   -> a source with exactly one pending write is released in the
//                same cycle its WB write happens (write-first bank / forward)
//   undefined -> a source is busy whenever its counter is non-zero
module id_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    id_scoreboard_if.slave sb
);

    localparam int unsigned      NREG    = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_err;

    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_inc_vec;
    logic [NREG-1:0] w_dec_vec;
    logic            w_busy_rs;
    logic            w_busy_rt;
    logic            w_sat;
    logic            w_stall;
    logic            w_issue;
    logic            w_inc;
    logic            w_dec;
    logic            w_idle;
    logic            w_unused_instr;

    assign w_rs = sb.instruccion[25:21];
    assign w_rt = sb.instruccion[20:16];
    assign w_unused_instr = ^{sb.instruccion[31:26], sb.instruccion[15:0]};

    assign w_dec = sb.wb_RegWrite && (sb.wb_WriteRegister != 5'd0);

    // Per-register busy view; $0 is never busy.
    always_comb begin
        w_busy = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            w_busy[r] = (r_cnt[r] != '0);
`ifdef WB_BYPASS_EN
            if ((r_cnt[r] == CNT_ONE) && w_dec && (sb.wb_WriteRegister == 5'(r)))
                w_busy[r] = 1'b0;
`endif
        end
    end

    // Issue decision; sources are checked against the pre-issue counters,
    // so an instruction never stalls on its own destination.
    assign w_busy_rs = sb.id_valid && w_busy[w_rs];
    assign w_busy_rt = sb.id_valid && sb.id_uses_rt && w_busy[w_rt];
    assign w_sat     = sb.id_valid && sb.id_writes && (sb.id_dest != 5'd0)
                       && (r_cnt[sb.id_dest] == CNT_MAX);
    assign w_stall   = w_busy_rs || w_busy_rt || w_sat;
    assign w_issue   = sb.id_valid && !w_stall;
    assign w_inc     = w_issue && sb.id_writes && (sb.id_dest != 5'd0);

    assign w_inc_vec = w_inc ? (NREG'(1) << sb.id_dest) : '0;
    assign w_dec_vec = w_dec ? (NREG'(1) << sb.wb_WriteRegister) : '0;

    // Idle flag from registered counters only.
    always_comb begin
        w_idle = 1'b1;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (r_cnt[r] != '0) w_idle = 1'b0;
        end
    end

    // Counter update: simultaneous inc/dec on one register cancel out;
    // a release with nothing pending leaves the counter at 0 and flags err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt[0] <= '0;
            for (int unsigned r = 1; r < NREG; r++) begin
                if (w_inc_vec[r] && !w_dec_vec[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
                    if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - CNT_ONE;
                    else                r_err    <= 1'b1;
                end
            end
        end
    end

    assign sb.stall   = w_stall;
    assign sb.issue   = w_issue;
    assign sb.busy_rs = w_busy_rs;
    assign sb.busy_rt = w_busy_rt;
    assign sb.idle    = w_idle;
    assign sb.err     = r_err;

endmodule
